// File: rtl/uart_sample_rx.sv
// rtl/uart_sample_rx.sv - 8N1 UART receiver that pairs low/high bytes into 16-bit samples
// Glitch-rejecting start detect, framing-error break hold, and inter-byte gap timeout.
module uart_sample_rx #(
   parameter int CLK_FREQ = 10000,
   parameter int BAUD     = 1000,
   parameter int GAP_BITS = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx,
   output logic [15:0] sample,
   output logic        sample_valid,
   output logic [7:0]  byte_data,
   output logic        byte_valid,
   output logic        frame_err,
   output logic        timeout,
   output logic        busy
);
   localparam int DIV   = CLK_FREQ / BAUD;
   localparam int HALF  = DIV / 2;
   localparam int LIMIT = GAP_BITS * DIV;
   localparam int CW    = $clog2(DIV + 1);
   localparam int GW    = $clog2(LIMIT + 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   state_t         state_q, state_d;
   logic           sync1_q, rx_s_q;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     shift_q, shift_d;
   logic           half_q, half_d;
   logic [7:0]     low_q, low_d;
   logic [GW-1:0]  idle_q, idle_d;
   logic [15:0]    sample_q, sample_d;
   logic [7:0]     byte_q, byte_d;
   logic           sv_q, sv_d, bv_q, bv_d, fe_q, fe_d, to_q, to_d;
   logic           start_det, sample_pt, byte_good, stop_bad, gap_expire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
      end else begin
         sync1_q <= rx;
         rx_s_q  <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_det) state_d = S_START;
         S_START: if (sample_pt) state_d = rx_s_q ? S_IDLE : S_DATA;
         S_DATA:  if (sample_pt && bit_q == 3'd7) state_d = S_STOP;
         S_STOP:  if (sample_pt) state_d = rx_s_q ? S_IDLE : S_BREAK;
         S_BREAK: if (rx_s_q) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      start_det = (state_q == S_IDLE) && !rx_s_q;
      sample_pt = ((state_q == S_START) && (cnt_q == CW'(HALF))) ||
                  (((state_q == S_DATA) || (state_q == S_STOP)) && (cnt_q == CW'(DIV)));
      byte_good = (state_q == S_STOP) && sample_pt && rx_s_q;
      stop_bad  = (state_q == S_STOP) && sample_pt && !rx_s_q;
      // A start edge on the expiry cycle wins: the pending low byte survives.
      gap_expire = half_q && (state_q == S_IDLE) && !start_det && (idle_q == GW'(LIMIT - 1));
   end

   always_comb begin
      cnt_d    = cnt_q + CW'(1);
      bit_d    = bit_q;
      shift_d  = shift_q;
      half_d   = half_q;
      low_d    = low_q;
      idle_d   = '0;
      sample_d = sample_q;
      byte_d   = byte_q;
      sv_d     = 1'b0;
      bv_d     = 1'b0;
      fe_d     = stop_bad;
      to_d     = gap_expire;
      if (start_det || sample_pt)
         cnt_d = CW'(1);
      else if (state_q == S_IDLE || state_q == S_BREAK)
         cnt_d = '0;
      if (state_q == S_START && sample_pt)
         bit_d = 3'd0;
      if (state_q == S_DATA && sample_pt) begin
         bit_d   = bit_q + 3'd1;
         shift_d = {rx_s_q, shift_q[7:1]};
      end
      if (half_q && state_q == S_IDLE && !start_det && !gap_expire)
         idle_d = idle_q + GW'(1);
      if (byte_good) begin
         bv_d   = 1'b1;
         byte_d = shift_q;
         if (half_q) begin
            sample_d = {shift_q, low_q};
            sv_d     = 1'b1;
            half_d   = 1'b0;
         end else begin
            low_d  = shift_q;
            half_d = 1'b1;
         end
      end
      if (stop_bad || gap_expire)
         half_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         half_q   <= 1'b0;
         low_q    <= '0;
         idle_q   <= '0;
         sample_q <= '0;
         byte_q   <= '0;
         sv_q     <= 1'b0;
         bv_q     <= 1'b0;
         fe_q     <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         half_q   <= half_d;
         low_q    <= low_d;
         idle_q   <= idle_d;
         sample_q <= sample_d;
         byte_q   <= byte_d;
         sv_q     <= sv_d;
         bv_q     <= bv_d;
         fe_q     <= fe_d;
         to_q     <= to_d;
      end
   end

   assign sample       = sample_q;
   assign sample_valid = sv_q;
   assign byte_data    = byte_q;
   assign byte_valid   = bv_q;
   assign frame_err    = fe_q;
   assign timeout      = to_q;
   assign busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_sample_rx.sv
// tb/tb_uart_sample_rx.sv - directed table-driven bench for uart_sample_rx at DIV = 10
// Frames are driven with integer-rounded bit edges; a negedge monitor logs output events.
module tb_uart_sample_rx;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx = 1'b1;
   logic [15:0] sample;
   logic        sample_valid;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        frame_err;
   logic        timeout;
   logic        busy;

   uart_sample_rx #(.CLK_FREQ(10000), .BAUD(1000), .GAP_BITS(20)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx),
      .sample(sample), .sample_valid(sample_valid),
      .byte_data(byte_data), .byte_valid(byte_valid),
      .frame_err(frame_err), .timeout(timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int bv_cnt = 0, sv_cnt = 0, fe_cnt = 0, to_cnt = 0, sv_wide = 0;
   int last_bv_cyc = 0, last_sv_cyc = 0, last_fe_cyc = 0, last_to_cyc = 0;
   int last_bv_data = 0, last_sample = 0;
   logic sv_prev = 1'b0;

   always @(negedge clk) begin
      if (byte_valid === 1'b1) begin
         bv_cnt <= bv_cnt + 1; last_bv_cyc <= cyc; last_bv_data <= int'(byte_data);
      end
      if (sample_valid === 1'b1) begin
         sv_cnt <= sv_cnt + 1; last_sv_cyc <= cyc; last_sample <= int'(sample);
         if (sv_prev) sv_wide <= sv_wide + 1;
      end
      sv_prev <= (sample_valid === 1'b1);
      if (frame_err === 1'b1) begin fe_cnt <= fe_cnt + 1; last_fe_cyc <= cyc; end
      if (timeout === 1'b1) begin to_cnt <= to_cnt + 1; last_to_cyc <= cyc; end
   end

   int n_cmp = 0, n_fail = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Called at posedge+1; c0 is the cycle IDLE first sees the synchronized start bit.
   task automatic send_frame(input logic [7:0] d, input logic stopb, input int per10, output int c0);
      logic [9:0] lv;
      int prev, nxt;
      lv = {stopb, d, 1'b0};
      c0 = cyc + 2;
      prev = 0;
      for (int k = 0; k < 10; k++) begin
         rx = lv[k];
         nxt = ((k + 1) * per10 + 5) / 10;
         repeat (nxt - prev) @(posedge clk);
         #1;
         prev = nxt;
      end
   endtask

   task automatic idle_line(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int t);
      do @(negedge clk); while (cyc < t);
   endtask

   task automatic align;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [7:0]  d;
      logic        stopb;
      int          per10;
      int          idle;
      logic        exp_bv;
      logic        exp_fe;
      logic        exp_sv;
      logic [15:0] exp_s;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int c0, p, bv0, fe0, sv0, to0;
      vecs[0]  = '{8'h34, 1'b1, 100, 0,  1'b1, 1'b0, 1'b0, 16'h0000};
      vecs[1]  = '{8'h12, 1'b1, 100, 20, 1'b1, 1'b0, 1'b1, 16'h1234};
      vecs[2]  = '{8'h55, 1'b1, 100, 0,  1'b1, 1'b0, 1'b0, 16'h0000};
      vecs[3]  = '{8'hA5, 1'b0, 100, 20, 1'b0, 1'b1, 1'b0, 16'h0000};
      vecs[4]  = '{8'hCD, 1'b1, 100, 0,  1'b1, 1'b0, 1'b0, 16'h0000};
      vecs[5]  = '{8'hAB, 1'b1, 100, 20, 1'b1, 1'b0, 1'b1, 16'hABCD};
      vecs[6]  = '{8'h11, 1'b1, 104, 0,  1'b1, 1'b0, 1'b0, 16'h0000};
      vecs[7]  = '{8'h22, 1'b1, 104, 0,  1'b1, 1'b0, 1'b1, 16'h2211};
      vecs[8]  = '{8'h33, 1'b1, 104, 0,  1'b1, 1'b0, 1'b0, 16'h0000};
      vecs[9]  = '{8'h44, 1'b1, 104, 0,  1'b1, 1'b0, 1'b1, 16'h4433};
      vecs[10] = '{8'h5A, 1'b1, 104, 0,  1'b1, 1'b0, 1'b0, 16'h0000};
      vecs[11] = '{8'hC3, 1'b1, 104, 20, 1'b1, 1'b0, 1'b1, 16'hC35A};

      repeat (3) @(posedge clk);
      #2;
      chk("reset sample", int'(sample), 0);
      chk("reset sample_valid", int'(sample_valid), 0);
      chk("reset byte_data", int'(byte_data), 0);
      chk("reset byte_valid", int'(byte_valid), 0);
      chk("reset frame_err", int'(frame_err), 0);
      chk("reset timeout", int'(timeout), 0);
      chk("reset busy", int'(busy), 0);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      // 3-cycle low glitch on the line
      bv0 = bv_cnt; fe0 = fe_cnt;
      p = cyc; c0 = p + 2;
      rx = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rx = 1'b1;
      wait_cyc(c0 + 1); chk("glitch busy rise", int'(busy), 1);
      wait_cyc(c0 + 5); chk("glitch busy held", int'(busy), 1);
      wait_cyc(c0 + 6); chk("glitch busy fall", int'(busy), 0);
      align;
      idle_line(120);
      chk("glitch byte_valid count", bv_cnt - bv0, 0);
      chk("glitch frame_err count", fe_cnt - fe0, 0);

      for (int i = 0; i < 12; i++) begin
         bv0 = bv_cnt; fe0 = fe_cnt; sv0 = sv_cnt; to0 = to_cnt;
         send_frame(vecs[i].d, vecs[i].stopb, vecs[i].per10, c0);
         chk($sformatf("v%0d byte_valid count", i), bv_cnt - bv0, int'(vecs[i].exp_bv));
         if (vecs[i].exp_bv) begin
            chk($sformatf("v%0d byte_data", i), last_bv_data, int'(vecs[i].d));
            if (vecs[i].per10 == 100) chk($sformatf("v%0d byte_valid cycle", i), last_bv_cyc, c0 + 96);
         end
         chk($sformatf("v%0d frame_err count", i), fe_cnt - fe0, int'(vecs[i].exp_fe));
         if (vecs[i].exp_fe) chk($sformatf("v%0d frame_err cycle", i), last_fe_cyc, c0 + 96);
         chk($sformatf("v%0d sample_valid count", i), sv_cnt - sv0, int'(vecs[i].exp_sv));
         if (vecs[i].exp_sv) begin
            chk($sformatf("v%0d sample", i), last_sample, int'(vecs[i].exp_s));
            if (vecs[i].per10 == 100) chk($sformatf("v%0d sample_valid cycle", i), last_sv_cyc, c0 + 96);
         end
         chk($sformatf("v%0d timeout count", i), to_cnt - to0, 0);
         if (vecs[i].idle > 0) idle_line(vecs[i].idle);
      end
      chk("sample_valid width", sv_wide, 0);

      // Orphaned low byte dropped after 200 idle cycles
      to0 = to_cnt; sv0 = sv_cnt;
      send_frame(8'h77, 1'b1, 100, c0);
      wait_cyc(c0 + 96 + 210);
      chk("timeout count", to_cnt - to0, 1);
      chk("timeout cycle", last_to_cyc, c0 + 96 + 200);
      chk("timeout no sample", sv_cnt - sv0, 0);
      align;
      send_frame(8'h22, 1'b1, 100, c0);
      send_frame(8'h11, 1'b1, 100, c0);
      chk("post-timeout sample count", sv_cnt - sv0, 1);
      chk("post-timeout sample", last_sample, 16'h1122);
      idle_line(20);

      // Async reset during data bit 4 of a high byte
      send_frame(8'h99, 1'b1, 100, c0);
      bv0 = bv_cnt; sv0 = sv_cnt;
      p = cyc;
      fork
         send_frame(8'hF3, 1'b1, 100, c0);
         begin
            wait_cyc(p + 2 + 52);
            rst_n = 1'b0;
            #1;
            chk("async rst sample", int'(sample), 0);
            chk("async rst byte_data", int'(byte_data), 0);
            chk("async rst busy", int'(busy), 0);
            chk("async rst pulses", int'({sample_valid, byte_valid, frame_err, timeout}), 0);
            repeat (3) @(posedge clk);
            #2;
            rst_n = 1'b1;
         end
      join
      idle_line(20);
      chk("reset byte dropped", bv_cnt - bv0, 0);
      send_frame(8'hEF, 1'b1, 100, c0);
      send_frame(8'hBE, 1'b1, 100, c0);
      chk("post-reset sample count", sv_cnt - sv0, 1);
      chk("post-reset sample", last_sample, 16'hBEEF);
      chk("post-reset sample cycle", last_sv_cyc, c0 + 96);
      idle_line(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end
endmodule
